// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Latency: n/a. Backpressure: n/a.
package loader_pkg;

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_ACK,
        S_RUN
    } state_t;

    localparam logic [7:0] ACK_OK_DEF  = 8'hAA;
    localparam logic [7:0] ACK_ERR_DEF = 8'h55;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles four bytes little-endian into one 32-bit word; word_valid fires with the 4th byte.
// Latency: combinational on the completing byte. Backpressure: none, every in_valid is consumed.
module byte_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (in_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    asm_q[7:0]   <= in_byte;
                2'd1:    asm_q[15:8]  <= in_byte;
                2'd2:    asm_q[23:16] <= in_byte;
                default: ;
            endcase
        end
    end

    // The top byte bypasses the register so the word is usable in the same cycle.
    assign word_valid = in_valid && !clr && (byte_cnt == 2'd3);
    assign word       = {in_byte, asm_q};

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed UART image into memory, acknowledges it, then releases the core.
// Latency: mem_we one cycle after the word's 4th byte. Backpressure: none on rx; ACK waits for tx_busy low.
module prog_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS = 32'd4096,
    parameter logic [7:0]  ACK_OK    = ACK_OK_DEF,
    parameter logic [7:0]  ACK_ERR   = ACK_ERR_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        core_rstn,
    output logic        load_done,
    output logic        load_err
);

    state_t      state, state_n;
    logic [31:0] len, len_n;
    logic [31:0] word_cnt, word_cnt_n, word_cnt_inc;
    logic        mem_we_n;
    logic [31:0] mem_adr_n, mem_wdata_n;
    logic        load_err_n;
    logic        released, released_n;

    logic        pk_in_valid, pk_clr, pk_valid;
    logic [31:0] pk_word;

    // Bytes arriving after the image (ACK/RUN) never reach the packer.
    assign pk_in_valid = rx_valid && ((state == S_LEN) || (state == S_DATA));
    assign pk_clr      = (state == S_ACK) || (state == S_RUN);

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (pk_clr),
        .in_valid   (pk_in_valid),
        .in_byte    (rx_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    assign word_cnt_inc = word_cnt + 32'd1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_LEN;
            len       <= '0;
            word_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_adr   <= BASE_ADDR;
            mem_wdata <= '0;
            load_err  <= 1'b0;
            released  <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            word_cnt  <= word_cnt_n;
            mem_we    <= mem_we_n;
            mem_adr   <= mem_adr_n;
            mem_wdata <= mem_wdata_n;
            load_err  <= load_err_n;
            released  <= released_n;
        end
    end

    always_comb begin
        state_n     = state;
        len_n       = len;
        word_cnt_n  = word_cnt;
        mem_we_n    = 1'b0;
        mem_adr_n   = mem_adr;
        mem_wdata_n = mem_wdata;
        load_err_n  = load_err;
        released_n  = released;
        tx_start    = 1'b0;

        case (state)
            S_LEN: begin
                if (pk_valid) begin
                    len_n      = pk_word;
                    word_cnt_n = '0;
                    if (pk_word == 32'd0) begin
                        state_n = S_ACK;
                    end else begin
                        if (pk_word > MAX_WORDS) load_err_n = 1'b1;
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pk_valid) begin
                    // Overflow words are consumed but never written.
                    if (word_cnt < MAX_WORDS) begin
                        mem_we_n    = 1'b1;
                        mem_wdata_n = pk_word;
                        mem_adr_n   = word_addr(BASE_ADDR, word_cnt);
                    end
                    word_cnt_n = word_cnt_inc;
                    if (word_cnt_inc == len) state_n = S_ACK;
                end
            end
            S_ACK: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    released_n = 1'b1;
                    state_n    = S_RUN;
                end
            end
            S_RUN: ;
            default: state_n = S_LEN;
        endcase
    end

    assign tx_data   = ((state == S_ACK) || (state == S_RUN)) ? (load_err ? ACK_ERR : ACK_OK) : 8'h00;
    assign core_rstn = released;
    assign load_done = released;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    import loader_pkg::*;

    localparam int MAXW_A = 4096;
    localparam int MAXW_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, rx_valid, tx_busy;
    logic [7:0] rx_data;

    logic        a_tx_start, a_mem_we, a_core_rstn, a_load_done, a_load_err;
    logic [7:0]  a_tx_data;
    logic [31:0] a_mem_adr, a_mem_wdata;
    logic        b_tx_start, b_mem_we, b_core_rstn, b_load_done, b_load_err;
    logic [7:0]  b_tx_data;
    logic [31:0] b_mem_adr, b_mem_wdata;

    prog_loader dut_a (
        .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(a_tx_start), .tx_data(a_tx_data), .mem_we(a_mem_we), .mem_adr(a_mem_adr),
        .mem_wdata(a_mem_wdata), .core_rstn(a_core_rstn), .load_done(a_load_done), .load_err(a_load_err)
    );

    prog_loader #(.MAX_WORDS(MAXW_B)) dut_b (
        .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(b_tx_start), .tx_data(b_tx_data), .mem_we(b_mem_we), .mem_adr(b_mem_adr),
        .mem_wdata(b_mem_wdata), .core_rstn(b_core_rstn), .load_done(b_load_done), .load_err(b_load_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        int          at;
    } wr_t;

    wr_t exp_a[$];
    wr_t exp_b[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every write must match the next expected write in address, data and cycle.
    always @(negedge clk) begin
        if (a_mem_we === 1'b1) begin
            if (exp_a.size() == 0) chk("a_unexpected_write", a_mem_adr, 32'hFFFF_FFFF);
            else begin
                wr_t e;
                e = exp_a.pop_front();
                chk("a_wr_adr", a_mem_adr, e.adr);
                chk("a_wr_dat", a_mem_wdata, e.dat);
                chk("a_wr_cycle", cyc, e.at);
            end
        end
        if (b_mem_we === 1'b1) begin
            if (exp_b.size() == 0) chk("b_unexpected_write", b_mem_adr, 32'hFFFF_FFFF);
            else begin
                wr_t e;
                e = exp_b.pop_front();
                chk("b_wr_adr", b_mem_adr, e.adr);
                chk("b_wr_dat", b_mem_wdata, e.dat);
                chk("b_wr_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic check);
        @(negedge clk);
        rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_a.delete();
        exp_b.delete();
        if (check) begin
            chk("rst_mem_we", {31'd0, a_mem_we}, 0);
            chk("rst_mem_adr", a_mem_adr, 0);
            chk("rst_mem_wdata", a_mem_wdata, 0);
            chk("rst_tx_start", {31'd0, a_tx_start}, 0);
            chk("rst_tx_data", {24'd0, a_tx_data}, 0);
            chk("rst_core_rstn", {31'd0, a_core_rstn}, 0);
            chk("rst_load_done", {31'd0, a_load_done}, 0);
            chk("rst_load_err", {31'd0, b_load_err}, 0);
        end
        rstn = 1'b1;
    endtask

    // Drives one byte; edge_idx is the cycle number in which its write (if any) must appear.
    task automatic send_byte(input logic [7:0] b, output int edge_idx);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        edge_idx = cyc;
    endtask

    task automatic idle(input int gap);
        if (gap > 0) begin
            int n;
            n = $urandom_range(gap, 0);
            repeat (n) @(posedge clk);
        end
    endtask

    task automatic run_image(input logic [31:0] len, input logic [31:0] w[8], input int busy,
                             input int gap, input logic [7:0] ack_a, input logic [7:0] ack_b,
                             input logic err_a, input logic err_b);
        int  e;
        bit  seen;
        logic [31:0] cur;
        tx_busy = (busy > 0);
        for (int k = 0; k < 4; k++) begin
            send_byte(len[8*k +: 8], e);
            idle(gap);
        end
        for (int i = 0; i < int'(len); i++) begin
            cur = w[i % 8];
            for (int k = 0; k < 4; k++) begin
                send_byte(cur[8*k +: 8], e);
                if (k == 3) begin
                    if (i < MAXW_A) exp_a.push_back('{32'(i * 4), cur, e});
                    if (i < MAXW_B) exp_b.push_back('{32'(i * 4), cur, e});
                end
                if (!(k == 3 && i == int'(len) - 1)) idle(gap);
            end
        end
        if (busy > 0) begin
            // Junk bytes during the ACK wait must be ignored.
            for (int h = 0; h < busy; h++) begin
                @(negedge clk);
                chk("busy_no_tx_start", {31'd0, a_tx_start | b_tx_start}, 0);
                chk("busy_core_rstn", {31'd0, a_core_rstn}, 0);
                rx_valid = h[0];
                rx_data  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            tx_busy  = 1'b0;
        end
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (a_tx_start === 1'b1) seen = 1'b1;
        end
        chk("tx_start_seen", {31'd0, seen}, 1);
        if (seen) begin
            chk("a_ack", {24'd0, a_tx_data}, {24'd0, ack_a});
            chk("b_ack", {24'd0, b_tx_data}, {24'd0, ack_b});
            chk("b_tx_start", {31'd0, b_tx_start}, 1);
            chk("core_held_at_ack", {31'd0, a_core_rstn}, 0);
            @(negedge clk);
            chk("tx_start_single", {31'd0, a_tx_start}, 0);
            chk("a_core_rstn", {31'd0, a_core_rstn}, 1);
            chk("a_load_done", {31'd0, a_load_done}, 1);
            chk("b_core_rstn", {31'd0, b_core_rstn}, 1);
            chk("a_load_err", {31'd0, a_load_err}, {31'd0, err_a});
            chk("b_load_err", {31'd0, b_load_err}, {31'd0, err_b});
        end
        repeat (3) @(negedge clk);
        chk("a_writes_pending", exp_a.size(), 0);
        chk("b_writes_pending", exp_b.size(), 0);
        chk("core_stays_released", {31'd0, a_core_rstn}, 1);
    endtask

    typedef struct {
        logic [31:0] len;
        int          busy;
        int          gap;
        logic [31:0] w0, w1, w2, w3;
        logic [7:0]  ack_a, ack_b;
        logic        err_a, err_b;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] w[8];
        int e;
        rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;

        vecs[0] = '{32'd2, 0,  1, 32'h0000_0013, 32'h0010_0093, 32'h0, 32'h0, 8'hAA, 8'hAA, 1'b0, 1'b0};
        vecs[1] = '{32'd0, 0,  0, 32'h0, 32'h0, 32'h0, 32'h0, 8'hAA, 8'hAA, 1'b0, 1'b0};
        vecs[2] = '{32'd3, 0,  2, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h0, 8'hAA, 8'h55, 1'b0, 1'b1};
        vecs[3] = '{32'd2, 10, 0, 32'hCAFE_F00D, 32'h8000_0001, 32'h0, 32'h0, 8'hAA, 8'hAA, 1'b0, 1'b0};
        vecs[4] = '{32'd4, 0,  0, 32'h0102_0304, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'h0000_0000, 8'hAA, 8'h55, 1'b0, 1'b1};

        for (int v = 0; v < 5; v++) begin
            do_reset(v == 0);
            w = '{vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3, 32'h0, 32'h0, 32'h0, 32'h0};
            run_image(vecs[v].len, w, vecs[v].busy, vecs[v].gap,
                      vecs[v].ack_a, vecs[v].ack_b, vecs[v].err_a, vecs[v].err_b);
        end

        // Reset mid-image: partial bytes must not leak into the next load.
        do_reset(1'b0);
        send_byte(8'h01, e); send_byte(8'h00, e); send_byte(8'h00, e); send_byte(8'h00, e);
        send_byte(8'hAA, e); send_byte(8'hBB, e);
        do_reset(1'b1);
        w = '{32'hDDCC_BBAA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_image(32'd1, w, 0, 0, 8'hAA, 8'hAA, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            logic [31:0] len;
            len = $urandom_range(6, 0);
            for (int i = 0; i < 8; i++) w[i] = $urandom;
            do_reset(1'b0);
            run_image(len, w, $urandom_range(4, 0), $urandom_range(3, 0),
                      (len > MAXW_A) ? 8'h55 : 8'hAA, (len > MAXW_B) ? 8'h55 : 8'hAA,
                      len > MAXW_A, len > MAXW_B);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader sitting directly upstream of the RISC-V core.
- Receives a length-prefixed program image as bytes from the UART receiver.
- Packs the bytes little-endian into 32-bit words and writes them into instruction/data memory.
- Sends a one-byte acknowledge over UART TX.
- Holds the core in reset until the load completes, then releases it.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first program word
MAX_WORDS, 4096, memory capacity in words; an image longer than this is an error
ACK_OK, 8'hAA, byte sent on successful load
ACK_ERR, 8'h55, byte sent when length exceeded MAX_WORDS

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
rx_valid  in  1  one-cycle pulse: rx_data holds a new received byte
rx_data  in  8  received byte
tx_busy  in  1  UART transmitter busy; tx_start is ignored while high
tx_start  out  1  one-cycle pulse requesting transmission of tx_data
tx_data  out  8  byte to transmit
mem_we  out  1  memory write enable, one cycle per word
mem_adr  out  32  byte address of the write
mem_wdata  out  32  word to write
core_rstn  out  1  active-low reset to the core; low until load done
load_done  out  1  high once the core is released
load_err  out  1  sticky; set when the length exceeded MAX_WORDS

Behaviour:
- Clock and reset: one clock (clk); synchronous active-low reset (rstn), sampled on the rising edge of clk.
- Reset values:
  - state=S_LEN; byte_cnt=0; word_cnt=0; len=0.
  - tx_start=0, tx_data=0, mem_we=0, mem_adr=BASE_ADDR, mem_wdata=0.
  - core_rstn=0, load_done=0, load_err=0.
- A reset during any state aborts the load. The core is held in reset again and the next byte is treated as length byte 0.
- Byte packing: byte_cnt counts 0..3, advancing only on rx_valid.
  - byte k lands in bits [8k+7:8k] of a 32-bit shift/assembly register.
  - byte_cnt wraps 3->0.
- S_LEN: collects 4 bytes into len (little-endian).
  - On the 4th byte, len is latched, and word_cnt and byte_cnt are cleared.
  - If len==0 -> S_ACK.
  - Otherwise, load_err is set if len>MAX_WORDS; then -> S_DATA.
- S_DATA: on the rx_valid that completes a word (byte_cnt==3):
  - Next cycle: mem_we=1 for exactly one cycle, with mem_wdata = assembled word and mem_adr = BASE_ADDR + 4*word_cnt.
  - Writes are suppressed (mem_we stays 0) for word_cnt >= MAX_WORDS. The bytes are still consumed.
  - word_cnt increments. When the incremented value equals len -> S_ACK, entered in the same cycle mem_we is asserted.
  - Write latency: the 4th byte's rx_valid at cycle t gives mem_we at t+1.
- S_ACK:
  - tx_data = load_err ? ACK_ERR : ACK_OK.
  - In the first cycle with tx_busy==0, tx_start=1 for one cycle; then -> S_RUN.
  - rx_valid is ignored in S_ACK and S_RUN.
- S_RUN: core_rstn=1 and load_done=1 from the cycle after tx_start onward, until rstn. Terminal state.
- Arithmetic widths:
  - len and word_cnt are 32 bits; address computation wraps modulo 2^32.
  - MAX_WORDS comparison is unsigned.
- Simultaneous events: rx_valid coinciding with the mem_we cycle is accepted normally. No byte is dropped, because the assembly register is free once latched into mem_wdata.
- load_err does not block the core release; software or host checks the ACK byte.

Decomposition:
- Shared package (loader_pkg):
  - state enum: S_LEN, S_DATA, S_ACK, S_RUN.
  - default ACK_OK/ACK_ERR constants.
- One natural sub-module: byte_packer, a byte-to-word assembler.
  - Inputs: clk, rstn, clr, in_valid, in_byte.
  - Outputs: word_valid pulse, word[31:0].
  - Reused for both the length field and the data words.
- Top FSM, address generation and ACK logic stay in prog_loader.

Test Plan:
- Reset, then send len=2 (02 00 00 00), then 13 00 00 00 / 93 00 10 00 -> mem_we pulses at adr 0x0 data 0x00000013 and adr 0x4 data 0x00100093. tx_start with tx_data=0xAA. core_rstn rises the cycle after tx_start.
- len=0 (00 00 00 00) -> no mem_we; ACK 0xAA; load_done=1.
- MAX_WORDS=2, len=3, 12 data bytes -> exactly 2 writes (adr 0x0, 0x4); third word consumed but not written; load_err=1; ACK 0x55; core released.
- Hold tx_busy=1 for 10 cycles on entering S_ACK -> tx_start held off until tx_busy drops, then a single pulse. core_rstn stays 0 throughout.
- Assert rstn=0 after 2 data bytes, then resend a full len=1 image (01 00 00 00, AA BB CC DD) -> single write of 0xDDCCBBAA to BASE_ADDR. Earlier partial bytes are not merged.
- Byte stream with rx_valid every cycle (back-to-back) -> every word is written; mem_we spacing is 4 cycles; no loss.
